// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  // Loader states, in stream order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Bytes per 32-bit instruction word.
  localparam int LANES = 4;
  localparam int LANE_W = $clog2(LANES);

  // Length header: LEN_LO then LEN_HI.
  localparam int HDR_BYTES = 2;

  // Total stream length in bytes for a load of n_words words (header, data, checksum).
  function automatic int stream_bytes(input int n_words);
    return HDR_BYTES + LANES * n_words + 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, memory write port and core-control signals of the loader.
// The master side is the host/memory environment; the slave side is the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       words_written;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words: byte lane k lands in
// bits [8k+7:8k]. word_valid pulses combinationally with the lane-3 byte, and
// word then carries the complete assembled word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0]          lane;
  logic [8*(LANES-1)-1:0]     low_bytes;

  assign word_valid = byte_valid && (lane == LANE_W'(LANES - 1));
  assign word       = {byte_data, low_bytes};

  // Lane counter and storage for the lower three bytes of the word in progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane      <= '0;
      low_bytes <= '0;
    end else if (byte_valid) begin
      lane <= lane + 1'b1;
      if (!word_valid) begin
        low_bytes[8*lane +: 8] <= byte_data;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length header, streams words into the instruction
// memory at consecutive word-aligned addresses, checks an XOR checksum over
// header and data, and releases the core only after a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 48,
  parameter int ADDR_W      = 8
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  // The length limit is what keeps mem_addr from wrapping.
  if (LANES * DEPTH_WORDS > (1 << ADDR_W)) begin : g_addr_range_check
    $error("imem_loader: DEPTH_WORDS does not fit in the ADDR_W byte address space");
  end

  state_t            state, state_next;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [7:0]        chk;
  logic [15:0]       words_written;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              in_ready, cpu_hold, done, error;

  logic              byte_fire;
  logic              start_ok;
  logic [15:0]       len_full;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign byte_fire = bus.in_valid && in_ready;
  assign start_ok  = bus.start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign len_full  = {bus.in_data, len_lo};
  assign last_word = (words_written + 16'd1) == len;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (byte_fire && (state == ST_DATA)),
    .byte_data  (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (byte_fire) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (byte_fire) begin
          if (len_full > 16'(DEPTH_WORDS)) state_next = ST_ERR;
          else if (len_full == 16'd0)      state_next = ST_CHECK;
          else                             state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (word_valid && last_word) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        if (byte_fire) state_next = (bus.in_data == chk) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start_ok) state_next = ST_LEN_LO;
      end
      ST_ERR: begin
        error = 1'b1;
        if (start_ok) state_next = ST_LEN_LO;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Length capture, running checksum, word counter and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo        <= '0;
      len           <= '0;
      chk           <= '0;
      words_written <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        chk           <= '0;
        words_written <= '0;
      end else if (byte_fire && (state != ST_CHECK)) begin
        chk <= chk ^ bus.in_data;
      end
      if (byte_fire && (state == ST_LEN_LO)) len_lo <= bus.in_data;
      if (byte_fire && (state == ST_LEN_HI)) len    <= len_full;
      if (word_valid) begin
        mem_we        <= 1'b1;
        mem_addr      <= ADDR_W'({words_written, 2'b00});
        mem_wdata     <= word;
        words_written <= words_written + 16'd1;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = mem_addr;
  assign bus.mem_wdata     = mem_wdata;
  assign bus.cpu_hold      = cpu_hold;
  assign bus.done          = done;
  assign bus.error         = error;
  assign bus.words_written = words_written;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: streams framed loads (directed and
// random) and compares the observed memory writes and status against a
// queue-based model of the stream format.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH_WORDS = 48;
  localparam int ADDR_W      = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Write monitor: records every mem_we cycle, sampled on the falling edge.
  int                cyc = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [15:0]       wr_ww_q[$];
  int                wr_cyc_q[$];
  int                double_we = 0;
  bit                prev_we = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_ww_q.push_back(bus.words_written);
      wr_cyc_q.push_back(cyc);
      if (prev_we) double_we++;
    end
    prev_we = (bus.mem_we === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_monitor();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_ww_q.delete();
    wr_cyc_q.delete();
    double_we = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offers one byte, optionally after random idle cycles; returns at the
  // falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
  endtask

  // Runs one complete load and checks writes and final status against the model.
  task automatic run_load(input string name, input int n, input logic [31:0] words[$],
                          input bit force_chk, input logic [7:0] chk_byte, input bit gaps);
    logic [7:0] stream[$];
    logic [7:0] model_chk;
    bit         overflow, good, ok;
    bit         exp_done;
    int         exp_n;
    overflow = (n > DEPTH_WORDS);
    good     = 1'b0;
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (!overflow) begin
      for (int w = 0; w < n; w++)
        for (int k = 0; k < 4; k++) stream.push_back(words[w][8*k +: 8]);
      model_chk = 8'h00;
      foreach (stream[i]) model_chk ^= stream[i];
      good = !force_chk || (chk_byte == model_chk);
      stream.push_back(force_chk ? chk_byte : model_chk);
    end
    clear_monitor();
    pulse_start();
    ok = 1'b1;
    foreach (stream[i]) if (ok) send_byte(stream[i], gaps, ok);
    exp_done = !overflow && good;
    exp_n    = overflow ? 0 : n;

    checks++; if (bus.done !== exp_done) begin errors++;
      $display("FAIL %s done: got %b, required %b", name, bus.done, exp_done); end
    checks++; if (bus.error !== !exp_done) begin errors++;
      $display("FAIL %s error: got %b, required %b", name, bus.error, !exp_done); end
    checks++; if (bus.cpu_hold !== !exp_done) begin errors++;
      $display("FAIL %s cpu_hold: got %b, required %b", name, bus.cpu_hold, !exp_done); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL %s in_ready: got %b, required 0", name, bus.in_ready); end
    checks++; if (bus.words_written !== 16'(exp_n)) begin errors++;
      $display("FAIL %s words_written: got %0d, required %0d", name, bus.words_written, exp_n); end
    checks++; if (wr_addr_q.size() != exp_n) begin errors++;
      $display("FAIL %s write count: got %0d, required %0d", name, wr_addr_q.size(), exp_n); end
    checks++; if (double_we != 0) begin errors++;
      $display("FAIL %s mem_we width: got %0d multi-cycle pulses, required 0", name, double_we); end
    for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== ADDR_W'((4 * i) % (1 << ADDR_W))) begin errors++;
        $display("FAIL %s write %0d addr: got 0x%0h, required 0x%0h", name, i, wr_addr_q[i], (4 * i) % (1 << ADDR_W)); end
      checks++; if (wr_data_q[i] !== words[i]) begin errors++;
        $display("FAIL %s write %0d data: got 0x%08h, required 0x%08h", name, i, wr_data_q[i], words[i]); end
      checks++; if (wr_ww_q[i] !== 16'(i + 1)) begin errors++;
        $display("FAIL %s write %0d words_written: got %0d, required %0d", name, i, wr_ww_q[i], i + 1); end
    end
  endtask

  task automatic apply_reset();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL %s in_ready: got %b, required 0", name, bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++;
      $display("FAIL %s mem_we: got %b, required 0", name, bus.mem_we); end
    checks++; if (bus.mem_addr !== '0) begin errors++;
      $display("FAIL %s mem_addr: got 0x%0h, required 0", name, bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++;
      $display("FAIL %s mem_wdata: got 0x%08h, required 0", name, bus.mem_wdata); end
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++;
      $display("FAIL %s cpu_hold: got %b, required 1", name, bus.cpu_hold); end
    checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++;
      $display("FAIL %s done/error: got %b/%b, required 0/0", name, bus.done, bus.error); end
    checks++; if (bus.words_written !== 16'd0) begin errors++;
      $display("FAIL %s words_written: got %0d, required 0", name, bus.words_written); end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_values("reset");
  endtask

  task automatic test_single_word();
    logic [31:0] w[$];
    w = {32'hE3A00014};
    run_load("single_word", 1, w, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    run_load("back_to_back", 3, w, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      checks++; if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) begin errors++;
        $display("FAIL back_to_back write spacing %0d: got %0d cycles, required 4", i, wr_cyc_q[i] - wr_cyc_q[i-1]); end
    end
  endtask

  task automatic test_bad_checksum_then_reload();
    logic [31:0] w[$];
    w = {32'hE3A00014};
    // Header and data XOR to 0x56, so 0x00 must be rejected.
    run_load("bad_checksum", 1, w, 1'b1, 8'h00, 1'b0);
    w = {32'($urandom), 32'($urandom)};
    run_load("reload_after_error", 2, w, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overflow();
    logic [31:0] w[$];
    run_load("overflow_49", DEPTH_WORDS + 1, w, 1'b0, 8'h00, 1'b0);
    // Bytes offered while in ERR are ignored.
    bus.in_valid = 1'b1;
    repeat (4) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++; if (wr_addr_q.size() != 0 || bus.error !== 1'b1 || bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL overflow_idle writes/error/in_ready: got %0d/%b/%b, required 0/1/0",
               wr_addr_q.size(), bus.error, bus.in_ready); end
  endtask

  task automatic test_zero_length();
    logic [31:0] w[$];
    run_load("zero_length", 0, w, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_max_length();
    logic [31:0] w[$];
    for (int i = 0; i < DEPTH_WORDS; i++) w.push_back($urandom);
    run_load("max_length", DEPTH_WORDS, w, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random_loads();
    logic [31:0] w[$];
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 10);
      if ($urandom_range(0, 4) == 0) n = $urandom_range(DEPTH_WORDS + 1, 300);
      w.delete();
      for (int i = 0; i < n && i < DEPTH_WORDS; i++) w.push_back($urandom);
      run_load($sformatf("random_%0d", it), n, w, $urandom_range(0, 2) == 0,
               8'($urandom), $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w0;
    logic [7:0]  stream[$];
    bit          ok;
    w0 = $urandom;
    stream = {8'h04, 8'h00, w0[7:0], w0[15:8], w0[23:16], w0[31:24],
              8'($urandom), 8'($urandom)};
    clear_monitor();
    pulse_start();
    ok = 1'b1;
    foreach (stream[i]) if (ok) send_byte(stream[i], 1'b1, ok);
    bus.in_valid = 1'($urandom);
    bus.in_data  = 8'($urandom);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_values("reset_mid_load");
    bus.in_valid = 1'b1;
    repeat (5) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++; if (wr_addr_q.size() != 1) begin errors++;
      $display("FAIL reset_mid_load write count: got %0d, required 1", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0) begin
      checks++; if (wr_addr_q[0] !== '0 || wr_data_q[0] !== w0) begin errors++;
        $display("FAIL reset_mid_load write: got 0x%0h/0x%08h, required 0x0/0x%08h",
                 wr_addr_q[0], wr_data_q[0], w0); end
    end
    check_reset_values("after_reset_idle");
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum_then_reload();
    test_overflow();
    test_zero_length();
    test_max_length();
    test_random_loads();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
